// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory port scheduler: FSM encoding, access
// size codes and parameter defaults.
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR      = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;

  localparam int MEM_LAT_DEF = 2;
  localparam int WR_HOLD_DEF = 3;

  // Byte and halfword accesses need a read-modify-write on stores.
  // Code 3 behaves as a word access.
  function automatic logic is_sub(input logic [1:0] sz);
    return (sz == SZ_BYTE) || (sz == SZ_HALF);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane handling: merges sub-word store data into a fetched
// word and extracts/sign-extends sub-word load data. Little-endian lanes.
module mem_lane_align
  import mem_sched_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  // Halfword lane uses addr[1] only; addr[0] is dropped.
  assign b_sel = word_i[{lane_i, 3'b000} +: 8];
  assign h_sel = word_i[{lane_i[1], 4'b0000} +: 16];

  // Word (and size code 3) passes through untouched in both directions.
  always_comb begin
    merged_o = word_i;
    load_o   = word_i;
    case (size_i)
      SZ_BYTE: begin
        merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
        load_o = {{24{b_sel[7]}}, b_sel};
      end
      SZ_HALF: begin
        merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i;
        load_o = {{16{h_sel[15]}}, h_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_port_sched.sv
// Single-port memory scheduler shared by instruction fetch and data access.
// Data side has fixed priority; one access in flight, never preempted.
// Sub-word stores are done as read-modify-write through the same read path.
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int WR_HOLD = WR_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  localparam logic [3:0] RD_CNT = 4'(MEM_LAT - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_HOLD - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        we_q;
  logic        own_d_q;     // 1: data side owns the access, 0: fetch
  logic [15:0] wdata_q;     // sub-word store data, merged after the read
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [31:0] merged, load_val;
  logic        accept, rd_last;

  assign accept  = (state_q == IDLE) && (d_req || if_req);
  assign rd_last = (state_q == RD_WAIT) && (cnt_q == 4'd0);

  mem_lane_align u_align (
    .word_i   (mem_rdata),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .wdata_i  (wdata_q),
    .merged_o (merged),
    .load_o   (load_val)
  );

  // Next-state logic; one down-counter times both the read wait and the write hold.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (d_req && d_we && !is_sub(d_size)) begin
          state_d = WR;
          cnt_d   = WR_CNT;
        end else if (d_req || if_req) begin
          state_d = RD_WAIT;
          cnt_d   = RD_CNT;
        end
      end
      RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (own_d_q && we_q) begin
            state_d = WR;
            cnt_d   = WR_CNT;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR: begin
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts whatever access is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture at accept, read data capture on the last wait edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      size_q      <= SZ_WORD;
      we_q        <= 1'b0;
      own_d_q     <= 1'b0;
      wdata_q     <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (accept) begin
        own_d_q <= d_req;
        addr_q  <= d_req ? d_addr : if_addr;
        size_q  <= d_req ? d_size : SZ_WORD;
        we_q    <= d_req && d_we;
        wdata_q <= d_wdata[15:0];
        if (d_req && d_we && !is_sub(d_size)) mem_wdata_q <= d_wdata;
      end
      if (rd_last) begin
        if (!own_d_q)  if_rdata_q  <= mem_rdata;
        else if (we_q) mem_wdata_q <= merged;
        else           d_rdata_q   <= load_val;
      end
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = (state_q == WR);
  assign if_done   = (state_q == DONE) && !own_d_q;
  assign d_done    = (state_q == DONE) && own_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: spec vector table, multi-cycle corner sequences
// and a randomized run against a byte-arithmetic memory model.
module tb_mem_port_sched;
  localparam int ML = 2;
  localparam int WH = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_done, d_req, d_we, d_done, mem_we;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  d_size;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] last_if, last_d;
  int nvec = 0;
  int nfail = 0;

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wd;
    logic [31:0] init;
    logic [31:0] exp;    // load result, or new memory word for stores
  } vec_t;
  vec_t vt [0:13];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[11:2]];

  mem_port_sched #(.MEM_LAT(ML), .WR_HOLD(WH)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance to the next falling edge; the memory commits any write seen there.
  task automatic step();
    @(negedge clk);
    if (mem_we === 1'b1) mem[mem_addr[11:2]] = mem_wdata;
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a, input logic [1:0] sz);
    int sh, v;
    if (sz == 2'd1) begin
      sh = 8 * int'(a[1:0]);
      v = int'((w >> sh) & 32'hFF);
      if (v >= 128) v -= 256;
      return 32'(v);
    end else if (sz == 2'd2) begin
      sh = 16 * int'(a[1]);
      v = int'((w >> sh) & 32'hFFFF);
      if (v >= 32768) v -= 65536;
      return 32'(v);
    end
    return w;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic [31:0] wd);
    int sh;
    if (sz == 2'd1) begin
      sh = 8 * int'(a[1:0]);
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end else if (sz == 2'd2) begin
      sh = 16 * int'(a[1]);
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[11:2]] = v;
    ref_mem[a[11:2]] = v;
  endtask

  // One complete access from the requester's point of view; entered and left
  // at a falling edge with the scheduler idle.
  task automatic run_op(input int kind, input logic [31:0] a, input logic [1:0] sz,
                        input logic [31:0] wd, input logic [31:0] exp);
    int cyc = 0, wecnt = 0, explat;
    logic got = 1'b0;
    logic [31:0] rd;
    if (kind == 0) begin
      if_req = 1'b1; if_addr = a;
      explat = ML + 1;
    end else begin
      d_req = 1'b1; d_we = (kind == 2); d_addr = a; d_size = sz; d_wdata = wd;
      explat = (kind == 1) ? ML + 1 : ((sz == 2'd1 || sz == 2'd2) ? ML + WH + 1 : WH + 1);
    end
    while (!got && cyc < 64) begin
      step();
      cyc++;
      if (mem_we) begin
        wecnt++;
        chk("mem_wdata during write", mem_wdata, exp);
        chk("mem_addr during write", mem_addr, {a[31:2], 2'b00});
      end
      if (if_done || d_done) begin
        got = 1'b1;
        chk("done owner", {30'd0, if_done, d_done}, (kind == 0) ? 32'd2 : 32'd1);
      end
    end
    if (!got) chk("done timeout", 32'd0, 32'd1);
    chk("latency", 32'(cyc), 32'(explat));
    chk("mem_we cycles", 32'(wecnt), (kind == 2) ? 32'(WH) : 32'd0);
    rd = (kind == 0) ? if_rdata : d_rdata;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if (kind == 2) begin
      chk("stored word", mem[a[11:2]], exp);
      ref_mem[a[11:2]] = exp;
      chk("d_rdata held", d_rdata, last_d);
    end else if (kind == 1) begin
      chk("load data", rd, exp);
      last_d = exp;
    end else begin
      chk("fetch data", rd, exp);
      last_if = exp;
      chk("d_rdata held", d_rdata, last_d);
    end
    if (kind != 0) chk("if_rdata held", if_rdata, last_if);
    step();
    chk("done one cycle", {30'd0, if_done, d_done}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int dc, ic, rel, wecnt;
    logic [31:0] a, wd, e;
    logic [1:0] sz;
    int kind;

    for (int i = 0; i < 1024; i++) begin mem[i] = 32'd0; ref_mem[i] = 32'd0; end
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_size = '0; d_wdata = '0;
    last_if = '0; last_d = '0;

    // Reset state.
    repeat (3) step();
    chk("rst mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst dones", {30'd0, if_done, d_done}, 32'd0);
    chk("rst if_rdata", if_rdata, 32'd0);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    step();

    // Directed vectors.
    vt[0]  = '{0, 32'h40,  2'd0, 32'h0,        32'h8C220004, 32'h8C220004};
    vt[1]  = '{0, 32'h47,  2'd3, 32'h0,        32'h12345678, 32'h12345678};
    vt[2]  = '{1, 32'h103, 2'd1, 32'h0,        32'h80FF1234, 32'hFFFFFF80};
    vt[3]  = '{1, 32'h102, 2'd2, 32'h0,        32'h80FF1234, 32'hFFFF80FF};
    vt[4]  = '{1, 32'h100, 2'd1, 32'h0,        32'h80FF1234, 32'h00000034};
    vt[5]  = '{1, 32'h101, 2'd2, 32'h0,        32'h80FF1234, 32'h00001234};
    vt[6]  = '{1, 32'h104, 2'd3, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF};
    vt[7]  = '{1, 32'h108, 2'd0, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};
    vt[8]  = '{2, 32'h101, 2'd1, 32'h000000AB, 32'h11223344, 32'h1122AB44};
    vt[9]  = '{2, 32'h103, 2'd2, 32'h0000BEEF, 32'h11223344, 32'hBEEF3344};
    vt[10] = '{2, 32'h10C, 2'd2, 32'h12345678, 32'hAABBCCDD, 32'hAABB5678};
    vt[11] = '{2, 32'h110, 2'd0, 32'h01020304, 32'hFFFFFFFF, 32'h01020304};
    vt[12] = '{2, 32'h114, 2'd3, 32'h0BADCAFE, 32'h00000000, 32'h0BADCAFE};
    vt[13] = '{2, 32'h117, 2'd1, 32'h00000077, 32'h00000000, 32'h77000000};
    for (int i = 0; i < 14; i++) begin
      preload(vt[i].addr, vt[i].init);
      run_op(vt[i].kind, vt[i].addr, vt[i].size, vt[i].wd, vt[i].exp);
    end

    // Both requesters at once: data first, fetch right after the bubble.
    preload(32'h100, 32'h13579BDF);
    preload(32'h40, 32'h2468ACE0);
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b0; d_size = 2'd0; d_addr = 32'h100;
    dc = 0; ic = 0;
    for (int c = 1; c <= 30 && ic == 0; c++) begin
      step();
      if (d_done) begin dc = c; d_req = 1'b0; end
      if (if_done) begin ic = c; if_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("arb d_done cycle", 32'(dc), 32'(ML + 1));
    chk("arb if_done cycle", 32'(ic), 32'(2 * (ML + 1) + 1));
    chk("arb d_rdata", d_rdata, 32'h13579BDF);
    chk("arb if_rdata", if_rdata, 32'h2468ACE0);
    last_d = 32'h13579BDF; last_if = 32'h2468ACE0;
    step();

    // Reset in the second write cycle of a word store, request kept high.
    preload(32'h300, 32'h0);
    d_req = 1'b1; d_we = 1'b1; d_size = 2'd0; d_addr = 32'h300; d_wdata = 32'h5A5A5A5A;
    step(); step();
    chk("pre-abort mem_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    step();
    chk("abort mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort d_done", {31'd0, d_done}, 32'd0);
    chk("abort d_rdata", d_rdata, 32'd0);
    chk("abort if_rdata", if_rdata, 32'd0);
    chk("abort mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    last_d = '0; last_if = '0;
    rel = 0; wecnt = 0;
    for (int c = 1; c <= 30 && rel == 0; c++) begin
      step();
      if (mem_we) wecnt++;
      if (d_done) rel = c;
    end
    d_req = 1'b0; d_we = 1'b0;
    chk("retry latency", 32'(rel), 32'(WH + 1));
    chk("retry mem_we cycles", 32'(wecnt), 32'(WH));
    chk("retry stored word", mem[32'h300 >> 2], 32'h5A5A5A5A);
    ref_mem[32'h300 >> 2] = 32'h5A5A5A5A;
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) preload(32'h400 + 32'(4 * i), $urandom);
    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = 32'h400 + 32'($urandom_range(0, 63));
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      if (kind == 0)      e = ref_mem[a[11:2]];
      else if (kind == 1) e = m_load(ref_mem[a[11:2]], a, sz);
      else                e = m_store(ref_mem[a[11:2]], a, sz, wd);
      run_op(kind, a, sz, wd, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_port_sched.md
MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL be the number of cycles from mem_addr stable to mem_rdata valid (range 1..15).
REQ-002 Parameter WR_HOLD, default 3, SHALL be the number of cycles mem_we is held high per write (range 1..15).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 if_req  input  1  SHALL be the instruction-fetch request, held high until if_done.
REQ-006 if_addr  input  32  SHALL be the fetch byte address; bits [1:0] are ignored.
REQ-007 if_done  output  1  SHALL be a one-cycle pulse that is high when if_rdata is valid.
REQ-008 if_rdata  output  32  SHALL be the fetched word, held until the next fetch completes.
REQ-009 d_req, d_we  input  1 each  SHALL be the data request and the write flag, held until d_done.
REQ-010 d_size  input  2  SHALL be the access size: 0=word, 1=byte, 2=halfword; 3 SHALL be treated as word.
REQ-011 d_addr, d_wdata  input  32 each  SHALL be the data byte address and the store data (low lanes used for sub-word stores).
REQ-012 d_done  output  1  SHALL be a one-cycle completion pulse.
REQ-013 d_rdata  output  32  SHALL be the load result, sign-extended for byte/halfword.
REQ-014 mem_addr, mem_wdata  output  32 each  SHALL be the memory word address (bits [1:0]=0) and the write data.
REQ-015 mem_we  output  1  SHALL be the memory write enable.
REQ-016 mem_rdata  input  32  SHALL be the memory read data.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, RD_WAIT, WR, DONE.
REQ-018 Requests SHALL be sampled only in IDLE.
REQ-019 When both requests are high, d_req SHALL win (fixed priority); an accepted access SHALL never be preempted.
REQ-020 On accept, the address, size, we, wdata and owner SHALL be registered; mem_addr SHALL be driven from the registered address only.
REQ-021 Fetch, load, and byte/halfword store SHALL enter RD_WAIT for exactly MEM_LAT cycles, then capture mem_rdata on the last RD_WAIT edge.
REQ-022 Word store SHALL go IDLE->WR directly.
REQ-023 Sub-word store SHALL go RD_WAIT->WR with mem_wdata = captured word with the addressed lane(s) replaced by d_wdata[7:0] or [15:0].
REQ-024 Lane selection SHALL be little-endian: byte lane = addr[1:0] (lane 0 = bits 7:0); halfword lane = addr[1]; addr[0] SHALL be ignored for halfword.
REQ-025 mem_we SHALL be high for exactly WR_HOLD cycles in WR, with mem_addr and mem_wdata stable throughout.
REQ-026 The FSM SHALL then enter DONE for one cycle, pulse the owner's done, and return to IDLE.
REQ-027 A request is therefore accepted no earlier than the cycle after DONE (one bubble).
REQ-028 Load result: word SHALL be passed through; byte/halfword SHALL be lane-extracted and sign-extended.
REQ-029 d_rdata SHALL update only on load completion.
REQ-030 Latency from accept edge to done: read = MEM_LAT+1 cycles; word store = WR_HOLD+1; sub-word store = MEM_LAT+WR_HOLD+1.
REQ-031 A single 4-bit down-counter SHALL time both RD_WAIT and WR.
REQ-032 mem_we SHALL be 0 in every state other than WR.

Reset
REQ-033 When rst is sampled high, the next state SHALL be IDLE regardless of the current state, aborting any access.
REQ-034 Reset SHALL clear all outputs and registers to 0: mem_we=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, mem_addr=0, mem_wdata=0.
REQ-035 No done pulse SHALL be issued for an aborted access.

Structure
REQ-036 Package mem_sched_pkg SHALL hold the state encoding, the size codes (SZ_WORD=0, SZ_BYTE=1, SZ_HALF=2) and the parameter defaults.
REQ-037 Sub-module mem_lane_align (combinational) SHALL perform store-lane merging and load extraction/sign-extension; it SHALL be instantiated once.

Verification
REQ-038 Fetch: if_req=1, if_addr=0x40, memory[0x40]=0x8C220004 -> if_done high in cycle 3 after accept, if_rdata=0x8C220004, mem_we never high.
REQ-039 LB: d_addr=0x103, memory[0x100]=0x80FF1234 -> d_rdata=0xFFFFFF80; LH at addr 0x102 -> d_rdata=0xFFFF80FF.
REQ-040 SB: d_addr=0x101, d_wdata=0xAB, memory word=0x11223344 -> mem_we high for 3 cycles with mem_wdata=0x1122AB44; d_done 6 cycles after accept.
REQ-041 Simultaneous if_req and d_req (word load) -> data served first; fetch accepted the cycle after d_done; if_done follows 3 cycles later.
REQ-042 Reset during WR (second mem_we cycle) -> mem_we=0 next cycle, FSM in IDLE, no d_done; a request held high is re-accepted after rst falls.
